register_file_8x16: RTL and testbench
=====================================

REGISTER_FILE_8X16 -- requirements
Module: register_file_8x16

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 16, register and port data width.
- ADDR_W, 3, register address width (8 registers).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- WE  input  1  write enable.
- WA  input  ADDR_W  write address.
- WD  input  DATA_W  write data.
- RA1  input  ADDR_W  read address, port 1 (feeds ALU operand A).
- RA2  input  ADDR_W  read address, port 2 (feeds ALU-source 2:1 16-bit mux I0 input).
- RD1  output  DATA_W  read data, port 1.
- RD2  output  DATA_W  read data, port 2.
- DA  input  ADDR_W  debug read address (board display).
- DD  output  DATA_W  debug read data.

REQ-003 The design SHALL have one clock (CLK) and a synchronous, active-high reset (RST); there are no other clocks and no asynchronous resets.

Function
REQ-004 Storage SHALL be 8 registers R0..R7, each DATA_W bits wide.
REQ-005 R0 SHALL always read 16'h0000; writes to WA=0 SHALL be discarded.
REQ-006 When WE=1, RST=0 and WA!=0 at a rising CLK edge, register WA SHALL load WD; all other registers SHALL hold.
REQ-007 When WE=0, no register SHALL change.
REQ-008 RD1, RD2 and DD SHALL be combinational (zero-cycle latency) functions of RA1, RA2, DA and the current register contents.
REQ-009 Write-then-read timing SHALL be as follows. There is no write-through bypass. A read of WA during the write cycle returns the old value. The new value is visible from the cycle after the edge.
REQ-010 Reads SHALL be independent: RA1=RA2=DA SHALL return identical data on all three ports.
REQ-011 Any X or Z on WA while WE=0 SHALL NOT alter state.

Reset
REQ-012 RST=1 at a rising CLK edge SHALL clear R1..R7 to 16'h0000. Reset has priority over WE.
REQ-013 A write asserted in the same cycle as RST SHALL be lost.
REQ-014 During reset, RD1, RD2 and DD SHALL reflect the cleared contents from the cycle after the reset edge.
REQ-015 Reset asserted mid-program SHALL take effect at the next edge without any pending-state residue.

Structure
REQ-016 DATA_W, ADDR_W and the register count (8) SHALL live in the shared project include/package. The zero-register constant (16'h0000) SHALL also live there.
REQ-017 Each storage element SHALL be one instance of the sub-module register_16_bit (CLK, RST, load-enable, D, Q), instantiated 7 times (R1..R7). R0 SHALL be a constant.
REQ-018 A 3-to-8 write decoder SHALL gate WE into per-register load-enables. Each read port SHALL be an 8:1 DATA_W-bit selector.
REQ-019 The design SHALL contain no latches.

Verification
REQ-020 Reset: preload all registers with 16'hFFFF, assert RST one cycle. Required: RA1/RA2/DA sweep 0..7 return 16'h0000.
REQ-021 Write/readback: write R3=16'h1234, then R7=16'hBEEF. Required: the next cycle RA1=3 gives RD1=16'h1234 and RA2=7 gives RD2=16'hBEEF.
REQ-022 R0 protection: WE=1, WA=0, WD=16'hA5A5. Required: RD1 with RA1=0 remains 16'h0000.
REQ-023 Same-cycle read of write target: R5=16'h0001, then write WD=16'h0002 to R5 with RA1=5. Required: RD1=16'h0001 in that cycle and 16'h0002 in the next cycle.
REQ-024 Reset/write collision: RST=1 and WE=1, WA=2, WD=16'h5555 in the same cycle. Required: R2 reads 16'h0000 afterwards.
REQ-025 Triple read: RA1=RA2=DA=4 after R4=16'h00FF. Required: all three outputs equal 16'h00FF. With WE=0 and random WA/WD for 20 cycles, no register changes.

Source files
------------

// File: rtl/register_file_8x16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_8x16_pkg
// Description : Shared sizes and constants for the 8x16 register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_8x16_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_NUM_REGS = 8;

    // R0 is hard-wired to this value rather than stored.
    localparam logic [RF_DATA_W-1:0] RF_ZERO = 16'h0000;

endpackage : register_file_8x16_pkg
`default_nettype wire

// File: rtl/register_file_8x16_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_8x16_if
// Description : Write, read and debug-read port bundle of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_8x16_if
    import register_file_8x16_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) ();

    logic              WE;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [ADDR_W-1:0] DA;
    logic [DATA_W-1:0] DD;

    modport master (
        output WE, WA, WD, RA1, RA2, DA,
        input  RD1, RD2, DD
    );

    modport slave (
        input  WE, WA, WD, RA1, RA2, DA,
        output RD1, RD2, DD
    );

endinterface : register_file_8x16_if
`default_nettype wire

// File: rtl/register_16_bit.sv
`default_nettype none
// ============================================================================
// Module      : register_16_bit
// Description : Load-enabled storage register with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_16_bit
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH = RF_DATA_W
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             le_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (le_i) begin
            data_d = d_i;
        end
    end

    // Clear wins over load so a write coincident with reset is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : register_16_bit
`default_nettype wire

// File: rtl/register_file_8x16.sv
`default_nettype none
// ============================================================================
// Module      : register_file_8x16
// Description : 8 x DATA_W register file, R0 constant, two read ports + debug.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_8x16
    import register_file_8x16_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    register_file_8x16_if.slave  bus
);

    localparam int NUM_REGS = RF_NUM_REGS;

    logic [NUM_REGS-1:0] w_le;
    logic [DATA_W-1:0]   w_regs [NUM_REGS];

    // AND-gating with WE keeps an unknown WA harmless while WE is low.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign w_le[gi] = bus.WE & (bus.WA == ADDR_W'(gi));
    end

    assign w_regs[0] = DATA_W'(RF_ZERO);

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        register_16_bit #(
            .WIDTH (DATA_W)
        ) u_reg (
            .CLK  (CLK),
            .RST  (RST),
            .le_i (w_le[gi]),
            .d_i  (bus.WD),
            .q_o  (w_regs[gi])
        );
    end

    // Unregistered selectors: a same-cycle read of the write target sees the old value.
    assign bus.RD1 = w_regs[bus.RA1];
    assign bus.RD2 = w_regs[bus.RA2];
    assign bus.DD  = w_regs[bus.DA];

    // w_le[0] is decoded but deliberately drives nothing.
    logic w_unused;
    assign w_unused = w_le[0];

endmodule : register_file_8x16
`default_nettype wire

// File: tb/tb_register_file_8x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_8x16
// Description : Directed scoreboard bench for register_file_8x16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_8x16;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] dd;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    logic chk_active;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [15:0] model [8];

    register_file_8x16_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    register_file_8x16 #(
        .DATA_W (16),
        .ADDR_W (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    // Monitor: outputs are combinational, so sample mid-cycle whenever a check is pending.
    always @(negedge clk) begin
        if (chk_active) begin
            n_checks = n_checks + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL sb_empty: got no expectation, want one");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.RD1 !== e.rd1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s RD1: got %h, want %h", e.name, bus.RD1, e.rd1);
                end
                n_checks = n_checks + 1;
                if (bus.RD2 !== e.rd2) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s RD2: got %h, want %h", e.name, bus.RD2, e.rd2);
                end
                n_checks = n_checks + 1;
                if (bus.DD !== e.dd) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s DD: got %h, want %h", e.name, bus.DD, e.dd);
                end
            end
        end
    end

    // One clock cycle of stimulus; the expectation applies before the next edge.
    task automatic step(input logic r, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] ad,
                        input logic chk, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] ed,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        bus.WE  = we;
        bus.WA  = wa;
        bus.WD  = wd;
        bus.RA1 = a1;
        bus.RA2 = a2;
        bus.DA  = ad;
        if (chk) begin
            e.rd1 = e1;
            e.rd2 = e2;
            e.dd  = ed;
            e.name = nm;
            sb.push_back(e);
        end
        chk_active = chk;
    endtask

    task automatic wr(input logic [2:0] wa, input logic [15:0] wd);
        step(1'b0, 1'b1, wa, wd, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, "");
    endtask

    initial begin
        logic [2:0] a1, a2, ad;
        n_checks   = 0;
        n_fail     = 0;
        chk_active = 1'b0;
        rst        = 1'b1;
        bus.WE     = 1'b0;
        bus.WA     = '0;
        bus.WD     = '0;
        bus.RA1    = '0;
        bus.RA2    = '0;
        bus.DA     = '0;

        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, "");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, "");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2, 3'd7, 1'b1, 16'h0, 16'h0, 16'h0, "reset_state");

        // Preload all writable registers, then reset for one cycle and sweep.
        for (int i = 1; i < 8; i++) wr(3'(i), 16'hFFFF);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 3'd4, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, "preload");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd3, 3'd5, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, "pre_reset");
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 3'(i), 1'b1, 16'h0, 16'h0, 16'h0, "reset_sweep");

        wr(3'd3, 16'h1234);
        wr(3'd7, 16'hBEEF);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd7, 3'd0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, "readback");

        step(1'b0, 1'b1, 3'd0, 16'hA5A5, 3'd0, 3'd3, 3'd7, 1'b1, 16'h0000, 16'h1234, 16'hBEEF, "r0_write_cycle");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd3, 3'd7, 1'b1, 16'h0000, 16'h1234, 16'hBEEF, "r0_protect");

        wr(3'd5, 16'h0001);
        step(1'b0, 1'b1, 3'd5, 16'h0002, 3'd5, 3'd5, 3'd3, 1'b1, 16'h0001, 16'h0001, 16'h1234, "no_bypass");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 3'd5, 1'b1, 16'h0002, 16'hBEEF, 16'h0002, "after_write");

        step(1'b1, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd3, 3'd7, 1'b0, 16'h0, 16'h0, 16'h0, "");
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd3, 3'd7, 1'b1, 16'h0000, 16'h0000, 16'h0000, "rst_collision");

        wr(3'd4, 16'h00FF);
        wr(3'd6, 16'hCAFE);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 3'd4, 1'b1, 16'h00FF, 16'h00FF, 16'h00FF, "triple_read");

        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        model[4] = 16'h00FF;
        model[6] = 16'hCAFE;

        for (int c = 0; c < 20; c++) begin
            a1 = 3'($urandom_range(0, 7));
            a2 = 3'($urandom_range(0, 7));
            ad = 3'($urandom_range(0, 7));
            if (c == 10)
                step(1'b0, 1'b0, 3'bxxx, 16'($urandom), a1, a2, ad, 1'b1,
                     model[a1], model[a2], model[ad], "we0_wa_x");
            else
                step(1'b0, 1'b0, 3'($urandom), 16'($urandom), a1, a2, ad, 1'b1,
                     model[a1], model[a2], model[ad], "we0_hold");
        end
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 3'(i), 1'b1,
                 model[i], model[7 - i], model[i], "final_sweep");

        @(posedge clk);
        #1;
        chk_active = 1'b0;
        @(negedge clk);
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_8x16
`default_nettype wire
